// File: rtl/halt_resume_controller.sv
// Run-state owner for the core: freezes fetch on a halt request, drains the pipe, parks in HALTED
// and releases on a four-phase resume handshake. Optional single-step: define HALT_SINGLE_STEP_EN.
module halt_resume_controller #(
   parameter int PIPE_DEPTH = 5,
   parameter int CNT_W      = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_halt_req,
   input  logic             i_resume_req,
`ifdef HALT_SINGLE_STEP_EN
   input  logic             i_step_req,
`endif
   output logic             o_resume_ack,
   output logic             o_fetch_stall,
   output logic             o_skip_inst,
   output logic             o_halted,
   output logic [CNT_W-1:0] o_halt_count,
   output logic [2:0]       o_dbg_state
);

   localparam int DW = (PIPE_DEPTH < 1) ? 1 : $clog2(PIPE_DEPTH + 1);

   typedef enum logic [2:0] {
      S_RUN     = 3'd0,
      S_DRAIN   = 3'd1,
      S_HALTED  = 3'd2,
      S_RESUME  = 3'd3,
      S_HOLDOFF = 3'd4,
      S_STEP    = 3'd5
   } state_t;

   state_t           r_state;
   logic [DW-1:0]    r_drain_cnt;
   logic [DW-1:0]    r_holdoff_cnt;
   logic [CNT_W-1:0] r_halt_count;
   logic             r_fetch_stall;
   logic             r_skip_inst;
   logic             r_halted;
   logic             r_resume_ack;
`ifdef HALT_SINGLE_STEP_EN
   // Set while the core sits on the instruction that raised the halt; a step must skip it once.
   logic             r_parked_on_halt;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= S_RUN;
         r_drain_cnt   <= '0;
         r_holdoff_cnt <= '0;
         r_halt_count  <= '0;
         r_fetch_stall <= 1'b0;
         r_skip_inst   <= 1'b0;
         r_halted      <= 1'b0;
         r_resume_ack  <= 1'b0;
`ifdef HALT_SINGLE_STEP_EN
         r_parked_on_halt <= 1'b0;
`endif
      end else begin
         r_skip_inst <= 1'b0;
         unique case (r_state)
            S_RUN: begin
               if (i_halt_req) begin
                  r_state       <= S_DRAIN;
                  r_drain_cnt   <= DW'(PIPE_DEPTH - 1);
                  r_fetch_stall <= 1'b1;
                  if (r_halt_count != '1) r_halt_count <= r_halt_count + 1'b1;
`ifdef HALT_SINGLE_STEP_EN
                  r_parked_on_halt <= 1'b1;
`endif
               end
            end
            S_DRAIN: begin
               if (r_drain_cnt == '0) begin
                  r_state  <= S_HALTED;
                  r_halted <= 1'b1;
               end else begin
                  r_drain_cnt <= r_drain_cnt - 1'b1;
               end
            end
            S_HALTED: begin
               if (i_resume_req) begin
                  r_state      <= S_RESUME;
                  r_halted     <= 1'b0;
                  r_resume_ack <= 1'b1;
                  r_skip_inst  <= 1'b1;
`ifdef HALT_SINGLE_STEP_EN
                  r_parked_on_halt <= 1'b0;
               end else if (i_step_req) begin
                  r_state          <= S_STEP;
                  r_halted         <= 1'b0;
                  r_fetch_stall    <= 1'b0;
                  r_skip_inst      <= r_parked_on_halt;
                  r_parked_on_halt <= 1'b0;
`endif
               end
            end
            S_RESUME: begin
               if (!i_resume_req) begin
                  r_state       <= S_HOLDOFF;
                  r_resume_ack  <= 1'b0;
                  r_fetch_stall <= 1'b0;
                  r_holdoff_cnt <= DW'(PIPE_DEPTH);
               end
            end
            S_HOLDOFF: begin
               // The skipped instruction may still decode as SYSTEM; ignore halt_req until the pipe refills.
               if (r_holdoff_cnt == '0) r_state <= S_RUN;
               else                     r_holdoff_cnt <= r_holdoff_cnt - 1'b1;
            end
`ifdef HALT_SINGLE_STEP_EN
            S_STEP: begin
               r_state       <= S_DRAIN;
               r_drain_cnt   <= DW'(PIPE_DEPTH - 1);
               r_fetch_stall <= 1'b1;
            end
`endif
            default: begin
               r_state       <= S_RUN;
               r_fetch_stall <= 1'b0;
               r_halted      <= 1'b0;
               r_resume_ack  <= 1'b0;
            end
         endcase
      end
   end

   assign o_resume_ack  = r_resume_ack;
   assign o_fetch_stall = r_fetch_stall;
   assign o_skip_inst   = r_skip_inst;
   assign o_halted      = r_halted;
   assign o_halt_count  = r_halt_count;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_halt_resume_controller.sv
// Bench for halt_resume_controller: vector table, hand-written corner sequences and a
// timestamp-based reference model driven by random halt/resume/reset traffic.
module tb_halt_resume_controller;
   localparam int PD = 5;
   localparam int CW = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          halt_req;
   logic          resume_req;
   logic          resume_ack;
   logic          fetch_stall;
   logic          skip_inst;
   logic          halted;
   logic [CW-1:0] halt_count;
   logic [2:0]    dbg_state;

   always #5 clk = ~clk;

   halt_resume_controller #(.PIPE_DEPTH(PD), .CNT_W(CW)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_halt_req   (halt_req),
      .i_resume_req (resume_req),
`ifdef HALT_SINGLE_STEP_EN
      .i_step_req   (1'b0),
`endif
      .o_resume_ack (resume_ack),
      .o_fetch_stall(fetch_stall),
      .o_skip_inst  (skip_inst),
      .o_halted     (halted),
      .o_halt_count (halt_count),
      .o_dbg_state  (dbg_state)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_outs(input string tag, input logic fs, input logic sk, input logic ht,
                             input logic ak, input int cnt);
      check({tag, ".fetch_stall"}, 32'(fetch_stall), 32'(fs));
      check({tag, ".skip_inst"},   32'(skip_inst),   32'(sk));
      check({tag, ".halted"},      32'(halted),      32'(ht));
      check({tag, ".resume_ack"},  32'(resume_ack),  32'(ak));
      check({tag, ".halt_count"},  32'(halt_count),  32'(cnt));
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
   task automatic step(input logic h, input logic r);
      halt_req   = h;
      resume_req = r;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      halt_req   = 1'b0;
      resume_req = 1'b0;
      rst        = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Reference model: run state tracked as a mode plus absolute cycle deadlines.
   localparam int RUNNING = 0, DRAINING = 1, PARKED = 2, ACKING = 3, COOLING = 4;
   int m_mode, m_cyc, m_halted_at, m_run_at, m_ack_start, m_cnt;

   task automatic model_reset();
      m_mode = RUNNING;
      m_cyc  = 0;
      m_cnt  = 0;
      m_ack_start = -1;
   endtask

   task automatic model_edge(input logic h, input logic r);
      m_cyc++;
      case (m_mode)
         RUNNING: if (h) begin
            m_mode      = DRAINING;
            m_halted_at = m_cyc + PD;
            if (m_cnt < CMAX) m_cnt++;
         end
         DRAINING: if (m_cyc == m_halted_at) m_mode = PARKED;
         PARKED: if (r) begin
            m_mode      = ACKING;
            m_ack_start = m_cyc;
         end
         ACKING: if (!r) begin
            m_mode   = COOLING;
            m_run_at = m_cyc + PD + 1;
         end
         COOLING: if (m_cyc == m_run_at) m_mode = RUNNING;
         default: m_mode = RUNNING;
      endcase
   endtask

   typedef struct {
      logic h, r;
      logic fs, sk, ht, ak;
      int   cnt;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic h, input logic r, input logic fs, input logic sk,
                      input logic ht, input logic ak, input int cnt);
      vec_t v;
      v.h = h; v.r = r; v.fs = fs; v.sk = sk; v.ht = ht; v.ak = ak; v.cnt = cnt;
      tbl.push_back(v);
   endtask

   initial begin
      logic h_r, r_r;
      rst = 1'b0;
      halt_req = 1'b0;
      resume_req = 1'b0;

      // Vector table from reset: halt, ignored toggles in DRAIN, resume, holdoff, collision.
      add(0,0, 0,0,0,0, 0);
      add(1,0, 1,0,0,0, 1);
      add(0,0, 1,0,0,0, 1);
      add(1,0, 1,0,0,0, 1);
      add(0,0, 1,0,0,0, 1);
      add(0,0, 1,0,0,0, 1);
      add(0,1, 1,0,1,0, 1);
      add(0,0, 1,0,1,0, 1);
      add(0,1, 1,1,0,1, 1);
      add(1,1, 1,0,0,1, 1);
      add(1,0, 0,0,0,0, 1);
      for (int i = 0; i < 5; i++) add(1,0, 0,0,0,0, 1);
      add(0,1, 0,0,0,0, 1);
      add(1,1, 1,0,0,0, 2);
      for (int i = 0; i < 4; i++) add(0,1, 1,0,0,0, 2);
      add(0,1, 1,0,1,0, 2);
      add(0,1, 1,1,0,1, 2);
      for (int i = 0; i < 7; i++) add(0,0, 0,0,0,0, 2);

      do_reset();
      check("reset.state", 32'(dbg_state), 32'd0);
      check_outs("reset", 0, 0, 0, 0, 0);
      foreach (tbl[i]) begin
         step(tbl[i].h, tbl[i].r);
         check_outs($sformatf("vec%0d", i), tbl[i].fs, tbl[i].sk, tbl[i].ht, tbl[i].ak, tbl[i].cnt);
      end
      check("vec_end.state_run", 32'(dbg_state), 32'd0);

      // Asynchronous reset in the middle of DRAIN.
      do_reset();
      step(1, 0);
      step(0, 0);
      check("t1.pre_stall", 32'(fetch_stall), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_outs("t1.async", 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      check("t1.state", 32'(dbg_state), 32'd0);
      check_outs("t1.edge", 0, 0, 0, 0, 0);
      rst = 1'b0;

      // Exact halt latency and halt_count saturation over five halt/resume rounds.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         step(1, 0);
         check($sformatf("t5.round%0d.stall", k), 32'(fetch_stall), 32'd1);
         check($sformatf("t5.round%0d.count", k), 32'(halt_count), 32'((k + 1 > CMAX) ? CMAX : k + 1));
         for (int j = 0; j < PD - 1; j++) step(0, 0);
         check($sformatf("t5.round%0d.not_yet", k), 32'(halted), 32'd0);
         step(0, 0);
         check($sformatf("t5.round%0d.halted", k), 32'(halted), 32'd1);
         step(0, 1);
         check($sformatf("t5.round%0d.ack", k), 32'(resume_ack), 32'd1);
         step(0, 0);
         for (int j = 0; j < PD + 1; j++) step(0, 0);
         check($sformatf("t5.round%0d.run", k), 32'(dbg_state), 32'd0);
      end

      // Randomized traffic against the reference model.
      do_reset();
      model_reset();
      h_r = 1'b0;
      r_r = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         h_r = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 5) == 0) r_r = ~r_r;
         if ($urandom_range(0, 499) == 0) begin
            rst = 1'b1;
            step(h_r, r_r);
            rst = 1'b0;
            model_reset();
         end else begin
            step(h_r, r_r);
            model_edge(h_r, r_r);
         end
         check_outs($sformatf("rnd%0d", n),
                    m_mode inside {DRAINING, PARKED, ACKING},
                    (m_mode == ACKING) && (m_cyc == m_ack_start),
                    m_mode == PARKED,
                    m_mode == ACKING,
                    m_cnt);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
